// File: rtl/display_pkg.sv
// Shared definitions for the display refresh controller: FSM state encoding,
// the byte-sender address tags, and the control-byte builder.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRL    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_DATA    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } state_t;

  // Tag that marks the control (brightness / enable) byte on tx_pos.
  localparam logic [7:0] CTRL_TAG  = 8'hFF;
  // First display address; data byte k goes out at DATA_BASE + k.
  localparam logic [7:0] DATA_BASE = 8'hC0;
  // Fixed upper bits of the control byte.
  localparam logic [7:0] CTRL_BASE = 8'h80;

  // Control byte: 1 0 0 0 | on | bright[2:0]
  function automatic logic [7:0] ctrl_byte(input logic disp_on, input logic [2:0] bright);
    return CTRL_BASE | {4'b0000, disp_on, bright};
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Free-running refresh tick generator. Counts 0..CLK_HZ/REFRESH_HZ-1 and
// flags the wrap cycle with a single-cycle tick.
module refresh_timer #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int REFRESH_HZ = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int DIV = ((CLK_HZ / REFRESH_HZ) < 1) ? 1 : (CLK_HZ / REFRESH_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Period counter: wraps to zero after the last count of the period.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  // The tick is high during the cycle whose closing edge performs the wrap.
  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/display_refresh_ctrl.sv
// Display refresh controller: holds a small segment frame buffer and, on a
// refresh tick (or on demand), streams one control byte followed by the frame
// bytes to an external byte sender using a valid/busy handshake.
module display_refresh_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int REFRESH_HZ   = 1,
  parameter int NUM_BYTES    = 16,
  parameter int CMD_PAUSE    = CLK_HZ / 1000,
  parameter int AUTO_REFRESH = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       force_refresh,
  output logic       tx_valid,
  output logic [7:0] tx_pos,
  output logic [7:0] tx_value,
  input  logic       tx_busy,
  output logic       active,
  output logic       frame_done
);

  localparam logic [4:0]  NB5       = 5'(NUM_BYTES);
  localparam logic [3:0]  IDX_LAST  = 4'(NUM_BYTES - 1);
  localparam logic [31:0] PAUSE_LEN = 32'(CMD_PAUSE);

  state_t      r_state, w_next;
  logic        r_dirty;
  logic        r_disp_on;
  logic [2:0]  r_bright;
  logic [3:0]  r_idx;
  logic        r_ctrl_phase;   // 1 while the byte in flight is the control byte
  logic [31:0] r_pause_cnt;
  logic [7:0]  r_pos_hold;
  logic [7:0]  r_val_hold;
  logic        r_frame_done;
  logic [7:0]  r_buf [16];     // entries at or above NUM_BYTES are never written

  logic w_tick;
  logic w_start;
  logic w_wr_ok;
  logic w_sent;
  logic w_last;

  refresh_timer #(
    .CLK_HZ    (CLK_HZ),
    .REFRESH_HZ(REFRESH_HZ)
  ) u_timer (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .o_tick (w_tick)
  );

  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < NB5);
  // Ticks and force requests are only looked at in IDLE, so anything that
  // arrives mid-frame is dropped rather than queued.
  assign w_start = (r_state == ST_IDLE) &&
                   (force_refresh || (w_tick && ((AUTO_REFRESH != 0) || r_dirty)));
  assign w_sent  = (r_state == ST_WAIT_LO) && !tx_busy;
  assign w_last  = (r_idx == IDX_LAST);

  assign active     = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and sender outputs; pos/value fall back to the held copies.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_pos   = r_pos_hold;
    tx_value = r_val_hold;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_CTRL;
      ST_CTRL: begin
        tx_pos   = CTRL_TAG;
        tx_value = ctrl_byte(r_disp_on, r_bright);
        tx_valid = !tx_busy && RST_N;
        if (!tx_busy) w_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (tx_busy) w_next = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (r_ctrl_phase) w_next = ST_PAUSE;
          else if (w_last)  w_next = ST_IDLE;
          else              w_next = ST_DATA;
        end
      end
      ST_PAUSE:   if ((r_pause_cnt + 32'd1) >= PAUSE_LEN) w_next = ST_DATA;
      ST_DATA: begin
        tx_pos   = DATA_BASE + {4'b0000, r_idx};
        tx_value = r_buf[r_idx];
        tx_valid = !tx_busy && RST_N;
        if (!tx_busy) w_next = ST_WAIT_HI;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: settings latch, byte index, pause timer, dirty flag,
  // held sender outputs and the end-of-frame pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dirty      <= 1'b1;
      r_disp_on    <= 1'b0;
      r_bright     <= '0;
      r_idx        <= '0;
      r_ctrl_phase <= 1'b0;
      r_pause_cnt  <= '0;
      r_pos_hold   <= '0;
      r_val_hold   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_sent && !r_ctrl_phase && w_last;

      if (w_start) begin
        r_disp_on <= display_on;
        r_bright  <= brightness;
        r_idx     <= '0;
      end else if (w_sent && !r_ctrl_phase && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end

      if (r_state == ST_CTRL)      r_ctrl_phase <= 1'b1;
      else if (r_state == ST_DATA) r_ctrl_phase <= 1'b0;

      if (r_state == ST_PAUSE) r_pause_cnt <= r_pause_cnt + 32'd1;
      else                     r_pause_cnt <= '0;

      if (tx_valid) begin
        r_pos_hold <= tx_pos;
        r_val_hold <= tx_value;
      end

      // A write landing on the same edge that starts a frame keeps dirty set.
      if (w_wr_ok)      r_dirty <= 1'b1;
      else if (w_start) r_dirty <= 1'b0;
    end
  end

  // Frame buffer; writes take effect immediately, even mid-frame.
  // NOTE: the buffer is reset on purpose: a reset must blank the display,
  // so this storage cannot be left to power-up contents like a plain RAM.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

endmodule
